// File: rtl/adder_operand_sequencer.sv
// Sequencer around a combinational full adder: collects A then B+cin over one
// valid/ready stream, lets the adder settle, and hands the result downstream.
module adder_operand_sequencer #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SETTLE = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   take_a;
    logic   take_b;
    logic   capture;
    logic   hand_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
        end else begin
            state <= state_next;
        end
    end

    // in_ready is gated by rst_n so upstream never sees a handshake during reset.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        take_a     = 1'b0;
        take_b     = 1'b0;
        capture    = 1'b0;
        hand_off   = 1'b0;
        case (state)
            LOAD_A: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    take_a     = 1'b1;
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    take_b     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                capture    = 1'b1;
                state_next = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    hand_off   = 1'b1;
                    state_next = LOAD_A;
                end
            end
            default: begin
                state_next = LOAD_A;
            end
        endcase
    end

    assign busy = (state != LOAD_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else begin
            if (take_a) begin
                add_a <= in_data;
            end
            if (take_b) begin
                add_b   <= in_data;
                add_cin <= in_cin;
            end
        end
    end

    // The adder has had a full cycle on stable operands by the end of SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (capture) begin
            out_sum  <= add_sum;
            out_cout <= add_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (hand_off) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Self-checking bench for adder_operand_sequencer; the attached adder is modelled
// behaviourally and results are predicted transaction by transaction.
module tb_adder_operand_sequencer;

    localparam int WIDTH = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_cin = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int fails = 0;
    int exp_count = 0;

    adder_operand_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_cin(in_cin), .in_valid(in_valid), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_sum(out_sum), .out_cout(out_cout), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .op_count(op_count)
    );

    // Behavioural 3-bit full adder attached to the sequencer
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};

    always #5 clk = ~clk;

    function automatic int ref_add(input int a, input int b, input int cin);
        return a + b + cin;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic c);
        int n = 0;
        in_data  = d;
        in_cin   = c;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            fails++;
            $display("[TB] FAIL send_timeout: in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            fails++;
            $display("[TB] FAIL result_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        exp_count = (exp_count + 1) % 256;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 9;
        if (add_a !== 3'd0)     begin fails++; $display("[TB] FAIL rst_add_a: got %0d required 0", add_a); end
        if (add_b !== 3'd0)     begin fails++; $display("[TB] FAIL rst_add_b: got %0d required 0", add_b); end
        if (add_cin !== 1'b0)   begin fails++; $display("[TB] FAIL rst_add_cin: got %b required 0", add_cin); end
        if (out_sum !== 3'd0)   begin fails++; $display("[TB] FAIL rst_out_sum: got %0d required 0", out_sum); end
        if (out_cout !== 1'b0)  begin fails++; $display("[TB] FAIL rst_out_cout: got %b required 0", out_cout); end
        if (op_count !== 8'd0)  begin fails++; $display("[TB] FAIL rst_op_count: got %0d required 0", op_count); end
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_out_valid: got %b required 0", out_valid); end
        if (busy !== 1'b0)      begin fails++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        if (in_ready !== 1'b0)  begin fails++; $display("[TB] FAIL rst_in_ready: got %b required 0", in_ready); end
        rst_n = 1'b1;
        exp_count = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rel_in_ready: got %b required 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int r = ref_add(3, 2, 0);
        send_beat(3'd3, 1'b0);
        checks += 3;
        if (add_a !== 3'd3)    begin fails++; $display("[TB] FAIL basic_add_a: got %0d required 3", add_a); end
        if (busy !== 1'b1)     begin fails++; $display("[TB] FAIL basic_busy: got %b required 1", busy); end
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL basic_ready_b: got %b required 1", in_ready); end
        send_beat(3'd2, 1'b0);
        checks += 3;
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_settle_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b0)  begin fails++; $display("[TB] FAIL basic_settle_ready: got %b required 0", in_ready); end
        if (add_b !== 3'd2)     begin fails++; $display("[TB] FAIL basic_add_b: got %0d required 2", add_b); end
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b1)      begin fails++; $display("[TB] FAIL basic_latency: out_valid=%b required 1", out_valid); end
        if (out_sum !== 3'(r % 8))   begin fails++; $display("[TB] FAIL basic_sum: got %0d required %0d", out_sum, r % 8); end
        if (out_cout !== 1'(r / 8))  begin fails++; $display("[TB] FAIL basic_cout: got %b required %0d", out_cout, r / 8); end
        if (op_count !== 8'd0)       begin fails++; $display("[TB] FAIL basic_count0: got %0d required 0", op_count); end
        release_result();
        checks += 3;
        if (op_count !== 8'(exp_count)) begin fails++; $display("[TB] FAIL basic_count1: got %0d required %0d", op_count, exp_count); end
        if (out_valid !== 1'b0)         begin fails++; $display("[TB] FAIL basic_drop_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b1)          begin fails++; $display("[TB] FAIL basic_next_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_carry();
        int va[2] = '{7, 4};
        int vb[2] = '{7, 4};
        int vc[2] = '{1, 0};
        for (int i = 0; i < 2; i++) begin
            int r = ref_add(va[i], vb[i], vc[i]);
            send_beat(3'(va[i]), 1'b0);
            send_beat(3'(vb[i]), 1'(vc[i]));
            wait_result();
            checks += 2;
            if (out_sum !== 3'(r % 8))  begin fails++; $display("[TB] FAIL carry_sum[%0d]: got %0d required %0d", i, out_sum, r % 8); end
            if (out_cout !== 1'(r / 8)) begin fails++; $display("[TB] FAIL carry_cout[%0d]: got %b required %0d", i, out_cout, r / 8); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int r = ref_add(6, 5, 0);
        send_beat(3'd6, 1'b0);
        send_beat(3'd5, 1'b0);
        wait_result();
        in_data  = 3'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 6;
            if (out_valid !== 1'b1)         begin fails++; $display("[TB] FAIL bp_valid[%0d]: got %b required 1", i, out_valid); end
            if (out_sum !== 3'(r % 8))      begin fails++; $display("[TB] FAIL bp_sum[%0d]: got %0d required %0d", i, out_sum, r % 8); end
            if (out_cout !== 1'(r / 8))     begin fails++; $display("[TB] FAIL bp_cout[%0d]: got %b required %0d", i, out_cout, r / 8); end
            if (in_ready !== 1'b0)          begin fails++; $display("[TB] FAIL bp_ready[%0d]: got %b required 0", i, in_ready); end
            if (op_count !== 8'(exp_count)) begin fails++; $display("[TB] FAIL bp_count[%0d]: got %0d required %0d", i, op_count, exp_count); end
            if (add_a !== 3'd6)             begin fails++; $display("[TB] FAIL bp_add_a[%0d]: got %0d required 6", i, add_a); end
        end
        in_valid = 1'b0;
        release_result();
        checks += 3;
        if (in_ready !== 1'b1)          begin fails++; $display("[TB] FAIL bp_release_ready: got %b required 1", in_ready); end
        if (busy !== 1'b0)              begin fails++; $display("[TB] FAIL bp_release_busy: got %b required 0", busy); end
        if (op_count !== 8'(exp_count)) begin fails++; $display("[TB] FAIL bp_release_count: got %0d required %0d", op_count, exp_count); end
    endtask

    task automatic test_input_gap();
        int r = ref_add(1, 6, 1);
        send_beat(3'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL gap_ready[%0d]: got %b required 1", i, in_ready); end
            if (busy !== 1'b1)     begin fails++; $display("[TB] FAIL gap_busy[%0d]: got %b required 1", i, busy); end
            if (add_a !== 3'd1)    begin fails++; $display("[TB] FAIL gap_add_a[%0d]: got %0d required 1", i, add_a); end
        end
        send_beat(3'd6, 1'b1);
        wait_result();
        checks += 2;
        if (out_sum !== 3'(r % 8))  begin fails++; $display("[TB] FAIL gap_sum: got %0d required %0d", out_sum, r % 8); end
        if (out_cout !== 1'(r / 8)) begin fails++; $display("[TB] FAIL gap_cout: got %b required %0d", out_cout, r / 8); end
        release_result();
    endtask

    task automatic test_reset_mid_op();
        int r = ref_add(1, 1, 0);
        send_beat(3'd5, 1'b0);
        send_beat(3'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks += 9;
        if (add_a !== 3'd0)     begin fails++; $display("[TB] FAIL mid_add_a: got %0d required 0", add_a); end
        if (add_b !== 3'd0)     begin fails++; $display("[TB] FAIL mid_add_b: got %0d required 0", add_b); end
        if (add_cin !== 1'b0)   begin fails++; $display("[TB] FAIL mid_add_cin: got %b required 0", add_cin); end
        if (out_sum !== 3'd0)   begin fails++; $display("[TB] FAIL mid_out_sum: got %0d required 0", out_sum); end
        if (out_cout !== 1'b0)  begin fails++; $display("[TB] FAIL mid_out_cout: got %b required 0", out_cout); end
        if (op_count !== 8'd0)  begin fails++; $display("[TB] FAIL mid_op_count: got %0d required 0", op_count); end
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_out_valid: got %b required 0", out_valid); end
        if (busy !== 1'b0)      begin fails++; $display("[TB] FAIL mid_busy: got %b required 0", busy); end
        if (in_ready !== 1'b0)  begin fails++; $display("[TB] FAIL mid_in_ready: got %b required 0", in_ready); end
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 2;
            if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_stale_valid[%0d]: got %b required 0", i, out_valid); end
            if (busy !== 1'b0)      begin fails++; $display("[TB] FAIL mid_idle_busy[%0d]: got %b required 0", i, busy); end
        end
        send_beat(3'd1, 1'b0);
        send_beat(3'd1, 1'b0);
        wait_result();
        checks += 2;
        if (out_sum !== 3'(r % 8))  begin fails++; $display("[TB] FAIL mid_new_sum: got %0d required %0d", out_sum, r % 8); end
        if (out_cout !== 1'(r / 8)) begin fails++; $display("[TB] FAIL mid_new_cout: got %b required %0d", out_cout, r / 8); end
        release_result();
        checks++;
        if (op_count !== 8'(exp_count)) begin fails++; $display("[TB] FAIL mid_new_count: got %0d required %0d", op_count, exp_count); end
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 20; i++) begin
            int a = int'($urandom_range(0, 7));
            int b = int'($urandom_range(0, 7));
            int c = int'($urandom_range(0, 1));
            int r = ref_add(a, b, c);
            send_beat(3'(a), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(3'(b), 1'(c));
            wait_result();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks += 2;
            if (out_sum !== 3'(r % 8))  begin fails++; $display("[TB] FAIL rand_sum[%0d]: got %0d required %0d", i, out_sum, r % 8); end
            if (out_cout !== 1'(r / 8)) begin fails++; $display("[TB] FAIL rand_cout[%0d]: got %b required %0d", i, out_cout, r / 8); end
            release_result();
        end
    endtask

    task automatic test_back_to_back_wrap();
        int exp_q[$];
        int pending_a = 0;
        int beat = 0;
        int results = 0;
        int cycle = 0;
        int last_rise = -1;
        int rises = 0;
        logic prev_valid = 1'b0;
        logic hs_in;
        logic hs_out;
        in_data   = 3'($urandom);
        in_cin    = 1'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (results < 256 && cycle < 256 * 4 + 40) begin
            checks++;
            if (op_count !== 8'(exp_count)) begin fails++; $display("[TB] FAIL wrap_count@%0d: got %0d required %0d", cycle, op_count, exp_count); end
            if (out_valid && !prev_valid) begin
                rises++;
                if (last_rise >= 0) begin
                    checks++;
                    if (cycle - last_rise != 4) begin fails++; $display("[TB] FAIL wrap_spacing@%0d: got %0d required 4", cycle, cycle - last_rise); end
                end
                last_rise = cycle;
            end
            prev_valid = out_valid;
            hs_in  = in_ready;
            hs_out = out_valid;
            if (hs_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL wrap_unexpected@%0d: got result %0d required none", cycle, {out_cout, out_sum});
                end else begin
                    int r = exp_q.pop_front();
                    if ({out_cout, out_sum} !== 4'(r)) begin fails++; $display("[TB] FAIL wrap_result@%0d: got %0d required %0d", cycle, {out_cout, out_sum}, r); end
                end
                results++;
            end
            if (hs_in) begin
                if (beat == 0) pending_a = int'(in_data);
                else exp_q.push_back(ref_add(pending_a, int'(in_data), int'(in_cin)));
                beat ^= 1;
            end
            @(posedge clk);
            if (hs_out) exp_count = (exp_count + 1) % 256;
            @(negedge clk);
            cycle++;
            if (hs_in) begin
                in_data = 3'($urandom);
                in_cin  = 1'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks += 3;
        if (results != 256)             begin fails++; $display("[TB] FAIL wrap_results: got %0d required 256", results); end
        if (rises != 256)               begin fails++; $display("[TB] FAIL wrap_rises: got %0d required 256", rises); end
        if (op_count !== 8'(exp_count)) begin fails++; $display("[TB] FAIL wrap_final_count: got %0d required %0d", op_count, exp_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_input_gap();
        test_reset_mid_op();
        test_random_ops();
        test_back_to_back_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
